// File: rtl/bridge_target_dataslot_requester.sv
// Core-side requester for target dataslot read/write commands, exposed as a bridge register window.
// Optional done-timeout abort is compiled in with `define DATASLOT_REQ_TIMEOUT_EN.
module bridge_target_dataslot_requester #(
    parameter logic [31:0] BASE_ADDR      = 32'hF800_0040,
    parameter int unsigned TIMEOUT_CYCLES = 74_250_000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [15:0] req_slot_id,
    input  logic [31:0] req_slot_offset,
    input  logic [31:0] req_bridge_addr,
    input  logic [31:0] req_length,
    input  logic [31:0] bridge_addr,
    input  logic        bridge_wr,
    input  logic [31:0] bridge_wr_data,
    input  logic        bridge_rd,
    output logic [31:0] bridge_rd_data,
    output logic        resp_valid,
    output logic [15:0] resp_result
);

    typedef enum logic [1:0] {StIdle, StPending, StAcked} state_e;

    state_e      state_q;
    logic        req_ready_q;
    logic        resp_valid_q;
    logic [15:0] resp_result_q;
    logic [31:0] rd_data_q;
    logic        write_q;
    logic [15:0] slot_id_q;
    logic [31:0] offset_q;
    logic [31:0] baddr_q;
    logic [31:0] length_q;

    logic        hit;
    logic [2:0]  word;
    logic        status_wr;
    logic        ack_wr;
    logic        done_wr;
    logic        busy;
    logic        accept;
    logic        expire;
    logic [15:0] opcode;
    logic [31:0] rd_word;
    logic        unused_addr;

    assign hit         = bridge_addr[31:5] == BASE_ADDR[31:5];
    assign word        = bridge_addr[4:2];
    assign unused_addr = ^bridge_addr[1:0];
    assign status_wr   = bridge_wr && hit && (word == 3'd1);
    assign ack_wr      = status_wr && (bridge_wr_data[31:16] == 16'h6163);
    assign done_wr     = status_wr && (bridge_wr_data[31:16] == 16'h6F6B);
    assign busy        = state_q != StIdle;
    assign accept      = req_valid && req_ready_q;
    assign opcode      = write_q ? 16'h0190 : 16'h0180;

    always_comb begin
        rd_word = 32'h0;
        case (word)
            3'd0:    rd_word = busy ? {16'h636D, opcode} : 32'h0;
            3'd2:    rd_word = {16'h0, slot_id_q};
            3'd3:    rd_word = offset_q;
            3'd4:    rd_word = baddr_q;
            3'd5:    rd_word = length_q;
            default: rd_word = 32'h0;
        endcase
    end

`ifdef DATASLOT_REQ_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

    logic [CntW-1:0] cnt_q;

    // Expires on the edge where the count would reach TIMEOUT_CYCLES.
    assign expire = busy && (cnt_q == CntLast);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (accept) begin
            cnt_q <= '0;
        end else if (busy) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
`else
    assign expire = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            req_ready_q   <= 1'b1;
            resp_valid_q  <= 1'b0;
            resp_result_q <= 16'h0;
            rd_data_q     <= 32'h0;
            write_q       <= 1'b0;
            slot_id_q     <= 16'h0;
            offset_q      <= 32'h0;
            baddr_q       <= 32'h0;
            length_q      <= 32'h0;
        end else begin
            resp_valid_q <= 1'b0;
            rd_data_q    <= (bridge_rd && hit) ? rd_word : 32'h0;
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        state_q     <= StPending;
                        req_ready_q <= 1'b0;
                        write_q     <= req_write;
                        slot_id_q   <= req_slot_id;
                        offset_q    <= req_slot_offset;
                        baddr_q     <= req_bridge_addr;
                        length_q    <= req_length;
                    end else begin
                        // Held low through the resp_valid cycle so no accept overlaps it.
                        req_ready_q <= 1'b1;
                    end
                end
                StPending, StAcked: begin
                    if (done_wr) begin
                        state_q       <= StIdle;
                        resp_valid_q  <= 1'b1;
                        resp_result_q <= bridge_wr_data[15:0];
                    end else if (expire) begin
                        state_q       <= StIdle;
                        resp_valid_q  <= 1'b1;
                        resp_result_q <= 16'hFFFF;
                    end else if (ack_wr && (state_q == StPending)) begin
                        state_q <= StAcked;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign req_ready      = req_ready_q;
    assign resp_valid     = resp_valid_q;
    assign resp_result    = resp_result_q;
    assign bridge_rd_data = rd_data_q;

endmodule

// File: tb/tb_bridge_target_dataslot_requester.sv
// Directed bench for bridge_target_dataslot_requester; timeout cases need DATASLOT_REQ_TIMEOUT_EN.
module tb_bridge_target_dataslot_requester;

    localparam logic [31:0] Base = 32'hF800_0040;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [15:0] req_slot_id = 16'h0;
    logic [31:0] req_slot_offset = 32'h0;
    logic [31:0] req_bridge_addr = 32'h0;
    logic [31:0] req_length = 32'h0;
    logic [31:0] bridge_addr = 32'h0;
    logic        bridge_wr = 1'b0;
    logic [31:0] bridge_wr_data = 32'h0;
    logic        bridge_rd = 1'b0;
    logic [31:0] bridge_rd_data;
    logic        resp_valid;
    logic [15:0] resp_result;

    int n_checks = 0;
    int n_errors = 0;
    int resp_cnt = 0;

    bridge_target_dataslot_requester #(
        .BASE_ADDR      (Base),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_write       (req_write),
        .req_slot_id     (req_slot_id),
        .req_slot_offset (req_slot_offset),
        .req_bridge_addr (req_bridge_addr),
        .req_length      (req_length),
        .bridge_addr     (bridge_addr),
        .bridge_wr       (bridge_wr),
        .bridge_wr_data  (bridge_wr_data),
        .bridge_rd       (bridge_rd),
        .bridge_rd_data  (bridge_rd_data),
        .resp_valid      (resp_valid),
        .resp_result     (resp_result)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (resp_valid) resp_cnt++;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // All tasks start and end at a falling edge.
    task automatic bus_read(input int w, output logic [31:0] data);
        bridge_addr = Base + 32'(w * 4);
        bridge_rd   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bridge_rd = 1'b0;
        data      = bridge_rd_data;
    endtask

    task automatic bus_write(input int w, input logic [31:0] data);
        bridge_addr    = Base + 32'(w * 4);
        bridge_wr_data = data;
        bridge_wr      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bridge_wr = 1'b0;
    endtask

    task automatic do_request(input logic wr, input logic [15:0] slot, input logic [31:0] off,
                              input logic [31:0] addr, input logic [31:0] len);
        req_write       = wr;
        req_slot_id     = slot;
        req_slot_offset = off;
        req_bridge_addr = addr;
        req_length      = len;
        req_valid       = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check_eq("req_ready_drop", req_ready, 1'b0);
    endtask

    task automatic read_check(input string tag, input int w, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(w, d);
        check_eq(tag, d, exp);
    endtask

    task automatic done_check(input string tag, input logic [31:0] data, input logic [15:0] exp);
        bus_write(1, data);
        check_eq({tag, "_valid"}, resp_valid, 1'b1);
        check_eq({tag, "_result"}, resp_result, exp);
        check_eq({tag, "_ready_in_resp"}, req_ready, 1'b0);
        @(negedge clk);
        check_eq({tag, "_pulse_end"}, resp_valid, 1'b0);
        check_eq({tag, "_ready_after"}, req_ready, 1'b1);
    endtask

    initial begin
        int c0;
        int n;

        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // Reset state
        check_eq("rst_ready", req_ready, 1'b1);
        check_eq("rst_resp_valid", resp_valid, 1'b0);
        check_eq("rst_rd_data", bridge_rd_data, 32'h0);
        for (int w = 0; w < 8; w++) read_check($sformatf("rst_word%0d", w), w, 32'h0);

        // Read request, full handshake
        do_request(1'b0, 16'h3, 32'h100, 32'h1000_0000, 32'h200);
        read_check("rd_cmd", 0, 32'h636D_0180);
        read_check("rd_slot", 2, 32'h3);
        read_check("rd_offset", 3, 32'h100);
        read_check("rd_baddr", 4, 32'h1000_0000);
        read_check("rd_len", 5, 32'h200);
        bus_write(2, 32'hDEAD_BEEF);
        read_check("ro_slot_kept", 2, 32'h3);
        c0 = resp_cnt;
        bus_write(1, 32'h1234_5678);
        @(negedge clk);
        check_eq("bad_status_no_resp", 32'(resp_cnt), 32'(c0));
        read_check("bad_status_cmd", 0, 32'h636D_0180);
        bus_write(1, 32'h6163_0000);
        done_check("rd_done", 32'h6F6B_0000, 16'h0000);
        read_check("rd_cmd_cleared", 0, 32'h0);
        read_check("rd_params_kept", 5, 32'h200);

        // Write request, done without ack
        do_request(1'b1, 16'h7, 32'h40, 32'h2000_0000, 32'h80);
        read_check("wr_cmd", 0, 32'h636D_0190);
        done_check("wr_done", 32'h6F6B_0002, 16'h0002);

        // "ok" while idle must not respond
        c0 = resp_cnt;
        bus_write(1, 32'h6F6B_0005);
        check_eq("idle_ok_valid", resp_valid, 1'b0);
        @(negedge clk);
        check_eq("idle_ok_no_resp", 32'(resp_cnt), 32'(c0));

        // req_valid held across a busy command
        req_write   = 1'b0;
        req_slot_id = 16'h9;
        req_valid   = 1'b1;
        @(negedge clk);
        check_eq("held_accepted", req_ready, 1'b0);
        req_slot_id = 16'hA;
        read_check("held_slot_first", 2, 32'h9);
        check_eq("held_still_busy", req_ready, 1'b0);
        done_check("held_done", 32'h6F6B_0003, 16'h0003);
        @(negedge clk);
        check_eq("held_reaccepted", req_ready, 1'b0);
        req_valid = 1'b0;
        read_check("held_slot_second", 2, 32'hA);
        done_check("held_done2", 32'h6F6B_0000, 16'h0000);

        // Async reset while ACKED
        do_request(1'b0, 16'h4, 32'h8, 32'h3000_0000, 32'h10);
        bus_write(1, 32'h6163_0000);
        c0 = resp_cnt;
        reset_n = 1'b0;
        #3;
        reset_n = 1'b1;
        check_eq("arst_ready", req_ready, 1'b1);
        check_eq("arst_resp_valid", resp_valid, 1'b0);
        @(negedge clk);
        check_eq("arst_no_resp", 32'(resp_cnt), 32'(c0));
        read_check("arst_cmd", 0, 32'h0);
        read_check("arst_slot", 2, 32'h0);
        do_request(1'b1, 16'h5, 32'h0, 32'h0, 32'h4);
        read_check("arst_new_cmd", 0, 32'h636D_0190);
        done_check("arst_new_done", 32'h6F6B_0009, 16'h0009);

`ifdef DATASLOT_REQ_TIMEOUT_EN
        // Silent host: abort 16 cycles after acceptance
        do_request(1'b0, 16'h1, 32'h0, 32'h0, 32'h4);
        n = 0;
        while (!resp_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_eq("tmo_cycles", 32'(n), 32'd16);
        check_eq("tmo_result", resp_result, 16'hFFFF);
        @(negedge clk);
        check_eq("tmo_ready", req_ready, 1'b1);
        read_check("tmo_cmd", 0, 32'h0);

        // Done write sampled on the expiry edge wins
        do_request(1'b0, 16'h2, 32'h0, 32'h0, 32'h4);
        repeat (15) @(negedge clk);
        c0 = resp_cnt;
        done_check("tmo_race", 32'h6F6B_0007, 16'h0007);
        @(negedge clk);
        check_eq("tmo_race_single", 32'(resp_cnt), 32'(c0 + 1));
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
